// File: rtl/inst_fetch_unit.sv
// Instruction fetch front end: issues word fetches on the SRAM-like channel, drops responses
// made stale by redirects, and queues returned words with their PC for decode.
module inst_fetch_unit #(
   parameter logic [31:0] RESET_PC = 32'hBFC00000,
   parameter int unsigned DEPTH    = 4
) (
   input  logic        clk,
   input  logic        rst,
   output logic        inst_req,
   output logic        inst_wr,
   output logic [1:0]  inst_size,
   output logic [31:0] inst_addr,
   output logic [31:0] inst_wdata,
   input  logic [31:0] inst_rdata,
   input  logic        inst_addr_ok,
   input  logic        inst_data_ok,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   output logic [31:0] out_pc,
   output logic [31:0] out_inst,
   output logic        out_adel,
   input  logic        out_ready
);
   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

   logic [31:0]   next_pc_q, next_pc_d, req_addr_q, req_addr_d, adel_pc_q, adel_pc_d;
   logic          pend_q, pend_d, halt_q, halt_d, adel_q, adel_d, started_q;
   logic [CW-1:0] outstanding_q, outstanding_d, discard_q, discard_d, f_cnt_q;
   logic [AW-1:0] ifq_wr_q, ifq_rd_q, f_wr_q, f_rd_q;
   logic [31:0]   ifq_mem   [DEPTH];
   logic [31:0]   fpc_mem   [DEPTH];
   logic [31:0]   finst_mem [DEPTH];
   logic          fadel_mem [DEPTH];
   logic          credit_ok, accept, drop, push, pop;
   logic [31:0]   push_pc, push_inst;

   assign inst_wr    = 1'b0;
   assign inst_size  = 2'b10;
   assign inst_wdata = '0;
   assign out_valid  = (f_cnt_q != '0);
   assign out_pc     = out_valid ? fpc_mem[f_rd_q] : '0;
   assign out_inst   = out_valid ? finst_mem[f_rd_q] : '0;
   assign out_adel   = out_valid ? fadel_mem[f_rd_q] : 1'b0;

   always_comb begin
      // In-flight requests plus buffered words never exceed the FIFO size, so no overflow.
      credit_ok = ({1'b0, outstanding_q} + {1'b0, f_cnt_q}) < DEPTH_W;
      inst_req  = pend_q || (started_q && !halt_q && credit_ok);
      inst_addr = pend_q ? req_addr_q : next_pc_q;
      accept    = inst_req && inst_addr_ok;
      drop      = inst_data_ok && (discard_q != '0);
      push      = adel_q || (inst_data_ok && !drop);
      pop       = out_valid && out_ready;
      push_pc   = adel_q ? adel_pc_q : ifq_mem[ifq_rd_q];
      push_inst = adel_q ? '0 : inst_rdata;
   end

   always_comb begin
      next_pc_d     = next_pc_q;
      req_addr_d    = req_addr_q;
      halt_d        = halt_q;
      adel_d        = 1'b0;
      adel_pc_d     = adel_pc_q;
      outstanding_d = outstanding_q + CW'(accept) - CW'(inst_data_ok);
      discard_d     = discard_q - CW'(drop);
      pend_d        = inst_req && !inst_addr_ok;
      // next_pc advances when a fresh address is first presented; a held request owns its own copy.
      if (inst_req && !pend_q) next_pc_d = next_pc_q + 32'd4;
      if (pend_d) req_addr_d = inst_addr;
      if (redirect_valid) begin
         next_pc_d = redirect_pc;
         discard_d = outstanding_d + CW'(pend_d);
         halt_d    = (redirect_pc[1:0] != 2'b00);
         adel_d    = halt_d;
         adel_pc_d = redirect_pc;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         next_pc_q     <= RESET_PC;
         req_addr_q    <= '0;
         adel_pc_q     <= '0;
         pend_q        <= 1'b0;
         halt_q        <= 1'b0;
         adel_q        <= 1'b0;
         started_q     <= 1'b0;
         outstanding_q <= '0;
         discard_q     <= '0;
         ifq_wr_q      <= '0;
         ifq_rd_q      <= '0;
         f_wr_q        <= '0;
         f_rd_q        <= '0;
         f_cnt_q       <= '0;
      end else begin
         next_pc_q     <= next_pc_d;
         req_addr_q    <= req_addr_d;
         adel_pc_q     <= adel_pc_d;
         pend_q        <= pend_d;
         halt_q        <= halt_d;
         adel_q        <= adel_d;
         started_q     <= 1'b1;
         outstanding_q <= outstanding_d;
         discard_q     <= discard_d;
         if (accept)       ifq_wr_q <= ifq_wr_q + AW'(1);
         if (inst_data_ok) ifq_rd_q <= ifq_rd_q + AW'(1);
         if (redirect_valid) begin
            f_wr_q  <= '0;
            f_rd_q  <= '0;
            f_cnt_q <= '0;
         end else begin
            if (push) f_wr_q <= f_wr_q + AW'(1);
            if (pop)  f_rd_q <= f_rd_q + AW'(1);
            f_cnt_q <= f_cnt_q + CW'(push) - CW'(pop);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (accept) ifq_mem[ifq_wr_q] <= inst_addr;
      if (push) begin
         fpc_mem[f_wr_q]   <= push_pc;
         finst_mem[f_wr_q] <= push_inst;
         fadel_mem[f_wr_q] <= adel_q;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(inst_data_ok && (outstanding_q == '0)))
            else $error("inst_data_ok with no request in flight");
      end
   end

endmodule

// File: tb/tb_inst_fetch_unit.sv
// Bench for inst_fetch_unit: directed scenarios followed by randomized slave/redirect traffic
// checked against a stream model (expected PC sequence per redirect epoch).
module tb_inst_fetch_unit;
   localparam logic [31:0] RST_PC = 32'hBFC00000;
   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst;
   logic        inst_req, inst_wr, inst_addr_ok, inst_data_ok;
   logic [1:0]  inst_size;
   logic [31:0] inst_addr, inst_wdata, inst_rdata;
   logic        redirect_valid, out_valid, out_adel, out_ready;
   logic [31:0] redirect_pc, out_pc, out_inst;

   inst_fetch_unit #(.RESET_PC(RST_PC), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst(rst), .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size),
      .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_rdata(inst_rdata),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok),
      .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
      .out_pc(out_pc), .out_inst(out_inst), .out_adel(out_adel), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   int n_tests = 0;
   int n_fail  = 0;
   int cyc = 0;
   int ao_mode = 0;  // 0: addr_ok=req, 1: random, 2: never
   int lat = 1;
   bit rand_lat = 1'b0;
   bit rst_v = 1'b1;
   logic [31:0] rsp_a[$];
   int          rsp_t[$];
   int acc_cnt = 0;
   int pop_cnt = 0;
   logic [31:0] exp_pc = RST_PC;
   logic [31:0] exp_adel_pc = '0;
   bit exp_halt = 1'b0;
   bit adel_seen = 1'b0;
   bit prev_pend = 1'b0;
   logic [31:0] prev_addr = '0;

   function automatic logic [31:0] memf(input logic [31:0] a);
      return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   // One cycle: drive inputs at negedge, check the visible state, update the models.
   task automatic tick(input bit rdy, input bit rv, input logic [31:0] rpc);
      bit dok, acc;
      @(negedge clk);
      cyc++;
      rst            = rst_v;
      out_ready      = rdy;
      redirect_valid = rv && !rst_v;
      redirect_pc    = rpc;
      if (rst_v) begin
         rsp_a.delete();
         rsp_t.delete();
      end
      dok = 1'b0;
      if (rsp_a.size() > 0) begin
         if (rsp_t[0] <= cyc) dok = (ao_mode != 1) || ($urandom_range(0, 3) != 0);
      end
      inst_data_ok = dok;
      inst_rdata   = dok ? memf(rsp_a[0]) : $urandom;
      case (ao_mode)
         0:       inst_addr_ok = inst_req;
         1:       inst_addr_ok = ($urandom_range(0, 2) != 0);
         default: inst_addr_ok = 1'b0;
      endcase
      if (rst_v) inst_addr_ok = 1'b0;
      acc = inst_req && inst_addr_ok;
      if (!rst_v) begin
         if (prev_pend) begin
            chk1("hold_req", inst_req, 1'b1);
            chk("hold_addr", inst_addr, prev_addr);
         end else if (exp_halt) begin
            chk1("halt_noreq", inst_req, 1'b0);
         end
         if (inst_req) chk1("addr_align", inst_addr[1:0] == 2'b00, 1'b1);
         if (out_valid && rdy && !rv) begin
            pop_cnt++;
            if (exp_halt) begin
               chk1("adel_once", adel_seen, 1'b0);
               chk1("adel_flag", out_adel, 1'b1);
               chk("adel_pc", out_pc, exp_adel_pc);
               chk("adel_inst", out_inst, 32'h0);
               adel_seen = 1'b1;
            end else begin
               chk1("pop_adel", out_adel, 1'b0);
               chk("pop_pc", out_pc, exp_pc);
               chk("pop_inst", out_inst, memf(exp_pc));
               exp_pc = exp_pc + 32'd4;
            end
         end
         if (dok) begin
            void'(rsp_a.pop_front());
            void'(rsp_t.pop_front());
         end
         if (acc) begin
            acc_cnt++;
            rsp_a.push_back(inst_addr);
            rsp_t.push_back(cyc + (rand_lat ? int'($urandom_range(1, 3)) : lat));
            chk1("inflight_le_depth", rsp_a.size() <= DEPTH, 1'b1);
         end
         if (rv) begin
            exp_pc      = rpc;
            exp_halt    = (rpc[1:0] != 2'b00);
            exp_adel_pc = rpc;
            adel_seen   = 1'b0;
         end
         prev_pend = inst_req && !inst_addr_ok;
         prev_addr = inst_addr;
      end else begin
         prev_pend = 1'b0;
         exp_pc    = RST_PC;
         exp_halt  = 1'b0;
         adel_seen = 1'b0;
      end
   endtask

   task automatic do_reset();
      rst_v = 1'b1;
      tick(1'b0, 1'b0, 32'h0);
      tick(1'b0, 1'b0, 32'h0);
      rst_v = 1'b0;
   endtask

   task automatic wait_req(input string tag, input bit rdy);
      int n = 0;
      while (!inst_req && n < 8) begin
         tick(rdy, 1'b0, 32'h0);
         n++;
      end
      chk1(tag, inst_req, 1'b1);
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!out_valid && n < 16) begin
         tick(1'b0, 1'b0, 32'h0);
         n++;
      end
      chk1(tag, out_valid, 1'b1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk1({tag, "_req"}, inst_req, 1'b0);
      chk1({tag, "_valid"}, out_valid, 1'b0);
      chk1({tag, "_adel"}, out_adel, 1'b0);
      chk({tag, "_pc"}, out_pc, 32'h0);
      chk({tag, "_inst"}, out_inst, 32'h0);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; out_ready = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
      inst_addr_ok = 1'b0; inst_data_ok = 1'b0; inst_rdata = '0;

      // Reset values
      do_reset();
      chk_reset_outputs("rst");
      chk1("rst_wr", inst_wr, 1'b0);
      chk({30'h0, inst_size}, {30'h0, inst_size} == 32'd2 ? 32'd2 : {30'h0, inst_size}, 32'd2);
      chk("rst_wdata", inst_wdata, 32'h0);

      // Streaming at one word per cycle
      ao_mode = 0; lat = 1;
      wait_req("s_req0", 1'b1);
      chk("s_addr0", inst_addr, 32'hBFC00000);
      tick(1'b1, 1'b0, 32'h0);
      chk("s_addr1", inst_addr, 32'hBFC00004);
      tick(1'b1, 1'b0, 32'h0);
      chk("s_addr2", inst_addr, 32'hBFC00008);
      chk1("s_valid", out_valid, 1'b1);
      chk("s_out0", out_pc, 32'hBFC00000);
      tick(1'b1, 1'b0, 32'h0);
      chk("s_out1", out_pc, 32'hBFC00004);

      // Back-pressure: exactly DEPTH requests, then one per pop
      do_reset();
      acc_cnt = 0;
      repeat (10) tick(1'b0, 1'b0, 32'h0);
      chk("full_acc", 32'(acc_cnt), 32'd4);
      chk1("full_noreq", inst_req, 1'b0);
      chk1("full_valid", out_valid, 1'b1);
      chk("full_head", out_pc, RST_PC);
      tick(1'b1, 1'b0, 32'h0);
      repeat (6) tick(1'b0, 1'b0, 32'h0);
      chk("refill_acc", 32'(acc_cnt), 32'd5);
      chk1("refill_noreq", inst_req, 1'b0);

      // Delayed addr_ok with a redirect during the wait
      do_reset();
      ao_mode = 2;
      wait_req("dly_req", 1'b1);
      chk("dly_addr0", inst_addr, RST_PC);
      tick(1'b1, 1'b0, 32'h0);
      chk("dly_addr1", inst_addr, RST_PC);
      tick(1'b1, 1'b1, 32'h80001000);
      chk("dly_addr2", inst_addr, RST_PC);
      ao_mode = 0;
      tick(1'b1, 1'b0, 32'h0);
      chk("dly_addr3", inst_addr, RST_PC);
      tick(1'b1, 1'b0, 32'h0);
      chk1("redir_req", inst_req, 1'b1);
      chk("redir_addr", inst_addr, 32'h80001000);
      pop_cnt = 0;
      repeat (4) tick(1'b1, 1'b0, 32'h0);
      chk1("redir_popped", pop_cnt > 0, 1'b1);

      // Redirect with two in flight plus a same-cycle response
      do_reset();
      lat = 2;
      wait_req("rd_req", 1'b1);
      tick(1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b1, 32'h80000000);
      wait_valid("rd_valid");
      chk("rd_head", out_pc, 32'h80000000);
      chk("rd_inst", out_inst, memf(32'h80000000));

      // Misaligned redirect produces a single address-error entry and halts
      tick(1'b0, 1'b1, 32'h80000002);
      repeat (2) tick(1'b0, 1'b0, 32'h0);
      chk1("ad_valid", out_valid, 1'b1);
      chk1("ad_flag", out_adel, 1'b1);
      chk("ad_pc", out_pc, 32'h80000002);
      chk("ad_inst", out_inst, 32'h0);
      chk1("ad_noreq", inst_req, 1'b0);
      tick(1'b1, 1'b0, 32'h0);
      repeat (3) tick(1'b1, 1'b0, 32'h0);
      chk1("ad_empty", out_valid, 1'b0);
      chk1("ad_halt", inst_req, 1'b0);
      tick(1'b1, 1'b1, 32'h80000010);
      tick(1'b1, 1'b0, 32'h0);
      chk1("resume_req", inst_req, 1'b1);
      chk("resume_addr", inst_addr, 32'h80000010);

      // Address wrap-around
      lat = 1;
      repeat (3) tick(1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b1, 32'hFFFFFFFC);
      tick(1'b1, 1'b0, 32'h0);
      chk("wrap_addr0", inst_addr, 32'hFFFFFFFC);
      tick(1'b1, 1'b0, 32'h0);
      chk1("wrap_req1", inst_req, 1'b1);
      chk("wrap_addr1", inst_addr, 32'h00000000);

      // Reset mid-operation with requests in flight
      lat = 2;
      repeat (6) tick(1'b1, 1'b0, 32'h0);
      rst_v = 1'b1;
      tick(1'b1, 1'b0, 32'h0);
      tick(1'b1, 1'b0, 32'h0);
      chk_reset_outputs("mrst");
      rst_v = 1'b0;
      wait_req("mrst_req", 1'b1);
      chk("mrst_addr", inst_addr, RST_PC);

      // Randomized slave timing, back-pressure and redirects
      ao_mode = 1; rand_lat = 1'b1; pop_cnt = 0;
      for (int i = 0; i < 3000; i++) begin
         bit rv;
         logic [31:0] t;
         rv = ($urandom_range(0, 39) == 0);
         case ($urandom_range(0, 7))
            0: begin
               t = $urandom;
               if (t[1:0] == 2'b00) t[0] = 1'b1;
            end
            1:       t = 32'hFFFFFFF0;
            default: t = $urandom & ~32'h3;
         endcase
         tick($urandom_range(0, 3) != 0, rv, t);
      end
      chk1("rand_pops", pop_cnt > 100, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/inst_fetch_unit.md
Name: inst_fetch_unit

Overview:
- Instruction fetch front end inside the mips core.
- Drives the core's SRAM-like instruction channel: inst_req/inst_wr/inst_size/inst_addr/inst_wdata out; inst_rdata/inst_addr_ok/inst_data_ok in.
- Tracks in-flight requests and discards responses made stale by a redirect.
- Buffers returned words with their PC in a FIFO for the decode stage.

Parameters:
- RESET_PC, 32'hBFC00000, first fetch address after reset.
- DEPTH, 4, output FIFO entries and max in-flight requests; power of two, >=2.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- inst_req  out  1  fetch request valid.
- inst_wr  out  1  constant 0.
- inst_size  out  2  constant 2'b10 (word).
- inst_addr  out  32  fetch address; word aligned.
- inst_wdata  out  32  constant 0.
- inst_rdata  in  32  returned instruction; valid when inst_data_ok.
- inst_addr_ok  in  1  request accepted this cycle.
- inst_data_ok  in  1  response returned this cycle; in-order.
- redirect_valid  in  1  branch/exception redirect, single-cycle pulse.
- redirect_pc  in  32  redirect target.
- out_valid  out  1  FIFO head valid.
- out_pc  out  32  PC of the head entry.
- out_inst  out  32  instruction of the head entry.
- out_adel  out  1  head entry is a fetch address-error marker.
- out_ready  in  1  decode accepts the head this cycle.

Behaviour:
- Reset values:
  - inst_req=0, out_valid=0, out_adel=0, out_pc=0, out_inst=0.
  - next_pc=RESET_PC; counters and FIFO empty; halt flag clear.
- Issue:
  - inst_req=1 when !halt && outstanding+fifo_count<DEPTH, or when a request is already pending.
  - First request is issued in the cycle after rst deasserts.
- Stable request: once inst_req=1 without inst_addr_ok, inst_req and inst_addr hold unchanged until inst_addr_ok. Only rst may drop a pending request.
- Acceptance (inst_req&&inst_addr_ok):
  - Push inst_addr into the in-flight PC queue (depth DEPTH); outstanding++.
  - next_pc = inst_addr+4, wrapping modulo 2^32.
  - With addr_ok combinational, the next request may issue in the following cycle; sustained throughput is 1 word/cycle.
- Response (inst_data_ok):
  - Pop the in-flight PC; outstanding--.
  - If discard_cnt>0: drop the word and discard_cnt--.
  - Else push {pc, inst_rdata, adel=0} into the FIFO.
  - The credit rule guarantees the FIFO never overflows; inst_data_ok with outstanding==0 is illegal (assertion).
- Output pop: on out_valid&&out_ready. Push and pop may occur in the same cycle; fifo_count is unchanged.
- Redirect, in the redirect_valid cycle:
  - FIFO flushed; a same-cycle pop is ignored.
  - discard_cnt <= outstanding + accept - (data_ok ? 1 : 0) + (pending_unaccepted ? 1 : 0). Every in-flight or still-pending request is discarded, and a same-cycle data_ok word is dropped.
  - next_pc <= redirect_pc. A pending unaccepted request keeps its address until accepted; the redirect target is issued after that.
  - halt cleared.
- Misaligned redirect (redirect_pc[1:0]!=0):
  - No fetch is issued; halt=1.
  - In the next cycle, push one entry {pc=redirect_pc, inst=0, adel=1} into the FIFO.
  - Issuing stays halted until the next redirect.
- Redirect takes priority over every other FIFO or next_pc update in the same cycle.
- Back-to-back redirects: the latest one wins; discard_cnt is recomputed each time.
- rst mid-operation: all state returns to reset values and the in-flight queue is cleared. The memory side is reset together with the core.

Test Plan:
- Reset release, slave with addr_ok=req and data_ok 1 cycle later, out_ready=1:
  - inst_addr sequence BFC00000, BFC00004, BFC00008 on consecutive cycles.
  - out_pc follows with 2-cycle latency, 1 entry/cycle.
- out_ready=0, DEPTH=4:
  - Exactly 4 requests accepted, then inst_req=0.
  - out_valid=1 holding BFC00000.
  - After one pop, exactly one new request issues.
- Slave delays addr_ok 3 cycles:
  - inst_req and inst_addr remain constant at BFC00000 throughout.
  - Redirect to 80001000 during the wait: BFC00000 is accepted, then its data is dropped; next request is 80001000.
- 2 outstanding plus a same-cycle data_ok at redirect to 80000000:
  - All 3 returned words dropped; first out_pc=80000000.
- Redirect to 80000002:
  - No inst_req.
  - Single entry out_adel=1, out_pc=80000002, out_inst=0.
  - Redirect to 80000010 resumes fetching.
- Fetch at FFFFFFFC:
  - Next inst_addr=00000000 (wrap-around).
- rst asserted with 2 outstanding:
  - Next cycle all outputs at reset values.
  - After release, first inst_addr=BFC00000.
